// File: rtl/chip8_sprite_fb_if.sv
// Bus bundle between a CHIP-8 core/display and chip8_sprite_fb.
// The framebuffer uses the slave side; the driving core uses master.
interface chip8_sprite_fb_if #(
    parameter int XW = 6,
    parameter int YW = 5
);
    logic [XW-1:0] pixel_x_in;
    logic [YW-1:0] pixel_y_in;
    logic          pixel_out;
    logic          swap_in;
    logic          clip_in;
    logic          draw_in;
    logic [11:0]   sprite_addr_in;
    logic [XW-1:0] sprite_x_in;
    logic [YW-1:0] sprite_y_in;
    logic [3:0]    sprite_n_in;
    logic          clear_in;
    logic [11:0]   mem_addr_out;
    logic          mem_req_out;
    logic [7:0]    mem_data_in;
    logic          busy_out;
    logic          done_out;
    logic          collision_out;

    modport slave (
        input  pixel_x_in, pixel_y_in, swap_in, clip_in, draw_in, sprite_addr_in,
               sprite_x_in, sprite_y_in, sprite_n_in, clear_in, mem_data_in,
        output pixel_out, mem_addr_out, mem_req_out, busy_out, done_out, collision_out
    );

    modport master (
        output pixel_x_in, pixel_y_in, swap_in, clip_in, draw_in, sprite_addr_in,
               sprite_x_in, sprite_y_in, sprite_n_in, clear_in, mem_data_in,
        input  pixel_out, mem_addr_out, mem_req_out, busy_out, done_out, collision_out
    );
endinterface

// File: rtl/chip8_sprite_fb.sv
// Double-buffered CHIP-8/SCHIP framebuffer: sprite fetch + XOR draw and clear
// into a back buffer, whole-buffer swap to the display-facing front buffer.
module chip8_sprite_fb #(
    parameter int XW      = 6,
    parameter int YW      = 5,
    parameter int MEM_LAT = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    chip8_sprite_fb_if.slave bus
);
    localparam int W = 1 << XW;
    localparam int H = 1 << YW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAW  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    logic [W-1:0]       back_mem  [H];
    logic [W-1:0]       front_mem [H];

    logic [1:0]         state_reg;
    logic [11:0]        addr_reg;
    logic [XW-1:0]      x_reg;
    logic [YW-1:0]      y_reg;
    logic [3:0]         n_reg;
    logic               clip_reg;
    logic [3:0]         fetch_cnt_reg;
    logic [3:0]         wr_cnt_reg;
    logic [MEM_LAT-1:0] vld_pipe_reg;
    logic [YW-1:0]      clr_row_reg;
    logic               swap_pend_reg;
    logic               done_reg;
    logic               coll_reg;
    logic               pixel_reg;

    logic               is_idle;
    logic               take_clear;
    logic               take_draw;
    logic               do_swap;
    logic               fetch_req;
    logic               data_vld;
    logic               last_row;
    logic [YW:0]        row_sum;
    logic               row_drop;
    logic [YW-1:0]      wr_row;
    logic [W-1:0]       old_row;
    logic [W-1:0]       sprite_mask;
    logic               row_hit;
    logic [7:0]         pix_en;
    logic [XW-1:0]      pix_col [8];

    assign is_idle    = (state_reg == ST_IDLE);
    assign take_clear = is_idle && bus.clear_in;
    assign take_draw  = is_idle && !bus.clear_in && bus.draw_in;
    assign do_swap    = is_idle && swap_pend_reg && !bus.clear_in && !bus.draw_in;

    assign fetch_req = (state_reg == ST_DRAW) && (fetch_cnt_reg < n_reg);
    assign data_vld  = (state_reg == ST_DRAW) && vld_pipe_reg[MEM_LAT-1];
    assign last_row  = data_vld && (wr_cnt_reg == n_reg - 4'd1);

    // Sums are one bit wider so the top bit flags an off-screen row/column.
    assign row_sum  = {1'b0, y_reg} + {{(YW-3){1'b0}}, wr_cnt_reg};
    assign row_drop = clip_reg && row_sum[YW];
    assign wr_row   = row_sum[YW-1:0];
    assign old_row  = back_mem[wr_row];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pix
            logic [XW:0] col_sum;
            assign col_sum     = {1'b0, x_reg} + (XW+1)'(gi);
            assign pix_en[gi]  = bus.mem_data_in[7-gi] && !(clip_reg && col_sum[XW]);
            assign pix_col[gi] = col_sum[XW-1:0];
        end
    endgenerate

    always_comb begin
        sprite_mask = '0;
        for (int k = 0; k < 8; k++) begin
            if (pix_en[k]) sprite_mask[pix_col[k]] = 1'b1;
        end
    end

    assign row_hit = !row_drop && (|(old_row & sprite_mask));

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            n_reg         <= '0;
            clip_reg      <= 1'b0;
            fetch_cnt_reg <= '0;
            wr_cnt_reg    <= '0;
            vld_pipe_reg  <= '0;
            clr_row_reg   <= '0;
            swap_pend_reg <= 1'b0;
            done_reg      <= 1'b0;
            coll_reg      <= 1'b0;
            pixel_reg     <= 1'b0;
            for (int r = 0; r < H; r++) begin
                back_mem[r]  <= '0;
                front_mem[r] <= '0;
            end
        end else begin
            done_reg  <= 1'b0;
            pixel_reg <= front_mem[bus.pixel_y_in][bus.pixel_x_in];

            // Request-valid delay line lines up each returned byte with its row.
            vld_pipe_reg[0] <= fetch_req;
            for (int i = 1; i < MEM_LAT; i++) vld_pipe_reg[i] <= vld_pipe_reg[i-1];

            if (do_swap) begin
                swap_pend_reg <= 1'b0;
                for (int r = 0; r < H; r++) front_mem[r] <= back_mem[r];
            end else if (bus.swap_in) begin
                swap_pend_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (take_clear) begin
                        state_reg   <= ST_CLEAR;
                        clr_row_reg <= '0;
                    end else if (take_draw) begin
                        addr_reg      <= bus.sprite_addr_in;
                        x_reg         <= bus.sprite_x_in;
                        y_reg         <= bus.sprite_y_in;
                        n_reg         <= bus.sprite_n_in;
                        clip_reg      <= bus.clip_in;
                        coll_reg      <= 1'b0;
                        fetch_cnt_reg <= '0;
                        wr_cnt_reg    <= '0;
                        if (bus.sprite_n_in == 4'd0) done_reg  <= 1'b1;
                        else                         state_reg <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (fetch_req) fetch_cnt_reg <= fetch_cnt_reg + 4'd1;
                    if (data_vld) begin
                        if (!row_drop) back_mem[wr_row] <= old_row ^ sprite_mask;
                        coll_reg   <= coll_reg | row_hit;
                        wr_cnt_reg <= wr_cnt_reg + 4'd1;
                        if (last_row) begin
                            state_reg <= ST_IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    back_mem[clr_row_reg] <= '0;
                    clr_row_reg           <= clr_row_reg + 1'b1;
                    if (&clr_row_reg) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.pixel_out     = pixel_reg;
    assign bus.mem_req_out   = fetch_req;
    assign bus.mem_addr_out  = fetch_req ? (addr_reg + {8'd0, fetch_cnt_reg}) : 12'd0;
    assign bus.busy_out      = !is_idle;
    assign bus.done_out      = done_reg;
    assign bus.collision_out = coll_reg;
endmodule

// File: tb/tb_chip8_sprite_fb.sv
// Directed bench for chip8_sprite_fb: 64x32/lat-2 instance for draw, clip/wrap,
// swap and clear; 128x64/lat-3 instance for wide edges and mid-draw reset.
module tb_chip8_sprite_fb;
    localparam int LAT_A = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n;
    logic rst_b_n;

    chip8_sprite_fb_if #(.XW(6), .YW(5)) ia ();
    chip8_sprite_fb_if #(.XW(7), .YW(6)) ib ();

    chip8_sprite_fb #(.XW(6), .YW(5), .MEM_LAT(2)) dut_a (
        .clk_in(clk), .rst_n_in(rst_a_n), .bus(ia.slave));
    chip8_sprite_fb #(.XW(7), .YW(6), .MEM_LAT(3)) dut_b (
        .clk_in(clk), .rst_n_in(rst_b_n), .bus(ib.slave));

    // Core memory models with fixed read latency; garbage when no data is due.
    logic [7:0]  sprite_mem [4096];
    logic [11:0] a_pipe_addr [2];
    logic [1:0]  a_pipe_v = '0;
    logic [11:0] b_pipe_addr [3];
    logic [2:0]  b_pipe_v = '0;

    always @(posedge clk) begin
        a_pipe_addr[0] <= ia.mem_addr_out;
        a_pipe_addr[1] <= a_pipe_addr[0];
        a_pipe_v       <= {a_pipe_v[0], ia.mem_req_out};
        b_pipe_addr[0] <= ib.mem_addr_out;
        b_pipe_addr[1] <= b_pipe_addr[0];
        b_pipe_addr[2] <= b_pipe_addr[1];
        b_pipe_v       <= {b_pipe_v[1:0], ib.mem_req_out};
    end
    assign ia.mem_data_in = a_pipe_v[1] ? sprite_mem[a_pipe_addr[1]] : 8'hA5;
    assign ib.mem_data_in = b_pipe_v[2] ? sprite_mem[b_pipe_addr[2]] : 8'h5A;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] m_back  [32];
    logic [63:0] m_front [32];
    logic [63:0] scan_rows [32];
    logic [11:0] exp_q [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_draw(input logic [11:0] addr, input int x, input int y, input int n,
                              input bit clip, output bit coll);
        logic [7:0] b;
        coll = 1'b0;
        for (int r = 0; r < n; r++) begin
            int row;
            row = y + r;
            b = sprite_mem[addr + 12'(r)];
            if (row >= 32) begin
                if (clip) continue;
                row -= 32;
            end
            for (int k = 0; k < 8; k++) begin
                int col;
                if (!b[7-k]) continue;
                col = x + k;
                if (col >= 64) begin
                    if (clip) continue;
                    col -= 64;
                end
                if (m_back[row][col]) coll = 1'b1;
                m_back[row][col] = ~m_back[row][col];
            end
        end
    endtask

    task automatic draw_a(input logic [11:0] addr, input int x, input int y, input int n,
                          input bit clip, input int swap_cyc, input int pix_exp);
        bit ecoll;
        int last;
        model_draw(addr, x, y, n, clip, ecoll);
        for (int r = 0; r < n; r++) exp_q.push_back(addr + 12'(r));
        ia.sprite_addr_in = addr;
        ia.sprite_x_in    = 6'(x);
        ia.sprite_y_in    = 5'(y);
        ia.sprite_n_in    = 4'(n);
        ia.clip_in        = clip;
        ia.draw_in        = 1'b1;
        tick();
        ia.draw_in = 1'b0;
        last = (n == 0) ? 1 : 1 + n + LAT_A;
        for (int c = 1; c <= last; c++) begin
            if (c > 1) tick();
            ia.swap_in = (c == swap_cyc);
            chk("mem_req", ia.mem_req_out, (c <= n));
            if (ia.mem_req_out) begin
                if (exp_q.size() == 0) chk("unexpected_mem_req", ia.mem_req_out, 1'b0);
                else                   chk("mem_addr", ia.mem_addr_out, exp_q.pop_front());
            end
            chk("busy", ia.busy_out, (n != 0) && (c <= n + LAT_A));
            chk("done", ia.done_out, (c == last));
            if (pix_exp >= 0) chk("pix_hold", ia.pixel_out, pix_exp[0]);
        end
        ia.swap_in = 1'b0;
        chk("collision", ia.collision_out, ecoll);
        chk("addr_queue_drained", exp_q.size(), 0);
    endtask

    task automatic swap_a();
        ia.swap_in = 1'b1;
        tick();
        ia.swap_in = 1'b0;
        tick();
        tick();
        for (int r = 0; r < 32; r++) m_front[r] = m_back[r];
    endtask

    task automatic clear_a();
        ia.clear_in = 1'b1;
        tick();
        ia.clear_in = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            if (c > 1) tick();
            chk("clear_busy", ia.busy_out, (c <= 32));
            chk("clear_done", ia.done_out, (c == 33));
        end
        for (int r = 0; r < 32; r++) m_back[r] = '0;
    endtask

    task automatic scan_a(input string tag);
        for (int y = 0; y < 32; y++) begin
            logic [63:0] row;
            for (int x = 0; x < 64; x++) begin
                ia.pixel_x_in = 6'(x);
                ia.pixel_y_in = 5'(y);
                tick();
                row[x] = ia.pixel_out;
            end
            scan_rows[y] = row;
            chk($sformatf("%s_row%0d", tag, y), row, m_front[y]);
        end
    endtask

    task automatic scan_b_zero(input string tag);
        for (int y = 0; y < 64; y++) begin
            logic [127:0] row;
            for (int x = 0; x < 128; x++) begin
                ib.pixel_x_in = 7'(x);
                ib.pixel_y_in = 6'(y);
                tick();
                row[x] = ib.pixel_out;
            end
            chk($sformatf("%s_row%0d", tag, y), row, 128'd0);
        end
    endtask

    task automatic pix_b(input string tag, input int x, input int y, input bit exp);
        ib.pixel_x_in = 7'(x);
        ib.pixel_y_in = 6'(y);
        tick();
        chk(tag, ib.pixel_out, exp);
    endtask

    task automatic outs_zero_b(input string tag);
        chk({tag, "_busy"}, ib.busy_out, 1'b0);
        chk({tag, "_done"}, ib.done_out, 1'b0);
        chk({tag, "_req"}, ib.mem_req_out, 1'b0);
        chk({tag, "_addr"}, ib.mem_addr_out, 12'd0);
        chk({tag, "_coll"}, ib.collision_out, 1'b0);
        chk({tag, "_pix"}, ib.pixel_out, 1'b0);
    endtask

    initial begin
        int dcyc;
        for (int i = 0; i < 4096; i++) sprite_mem[i] = 8'h00;
        sprite_mem[12'h200] = 8'hF0;
        sprite_mem[12'h201] = 8'h81;
        sprite_mem[12'h300] = 8'hFF;
        sprite_mem[12'h301] = 8'hFF;
        for (int r = 0; r < 32; r++) begin
            m_back[r]  = '0;
            m_front[r] = '0;
        end
        {ia.pixel_x_in, ia.pixel_y_in, ia.swap_in, ia.clip_in, ia.draw_in} = '0;
        {ia.sprite_addr_in, ia.sprite_x_in, ia.sprite_y_in, ia.sprite_n_in, ia.clear_in} = '0;
        {ib.pixel_x_in, ib.pixel_y_in, ib.swap_in, ib.clip_in, ib.draw_in} = '0;
        {ib.sprite_addr_in, ib.sprite_x_in, ib.sprite_y_in, ib.sprite_n_in, ib.clear_in} = '0;

        // Reset state
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        tick(); tick(); tick();
        chk("rst_a_busy", ia.busy_out, 1'b0);
        chk("rst_a_done", ia.done_out, 1'b0);
        chk("rst_a_req", ia.mem_req_out, 1'b0);
        chk("rst_a_addr", ia.mem_addr_out, 12'd0);
        chk("rst_a_coll", ia.collision_out, 1'b0);
        chk("rst_a_pix", ia.pixel_out, 1'b0);
        outs_zero_b("rst_b");
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        tick();
        scan_a("reset_front");

        // Basic draw, then identical redraw erases with collision
        draw_a(12'h200, 0, 0, 2, 1'b0, -1, -1);
        swap_a();
        scan_a("draw1");
        chk("draw1_row0_const", scan_rows[0], 64'h0F);
        chk("draw1_row1_const", scan_rows[1], 64'h81);
        draw_a(12'h200, 0, 0, 2, 1'b0, -1, -1);
        swap_a();
        scan_a("draw2");
        chk("draw2_row0_const", scan_rows[0], 64'h0);

        // Clip at the bottom-right corner, then wrap on a cleared buffer
        draw_a(12'h300, 60, 31, 2, 1'b1, -1, -1);
        swap_a();
        scan_a("clip");
        chk("clip_row31_const", scan_rows[31], 64'hF000_0000_0000_0000);
        chk("clip_row0_const", scan_rows[0], 64'h0);
        clear_a();
        draw_a(12'h300, 60, 31, 2, 1'b0, -1, -1);
        swap_a();
        scan_a("wrap");
        chk("wrap_row31_const", scan_rows[31], 64'hF000_0000_0000_000F);
        chk("wrap_row0_const", scan_rows[0], 64'hF000_0000_0000_000F);

        // Zero-row draw
        draw_a(12'h200, 5, 5, 0, 1'b0, -1, -1);

        // Swap requested mid-draw is held until the draw finishes
        ia.pixel_x_in = 6'd10;
        ia.pixel_y_in = 5'd5;
        tick(); tick();
        draw_a(12'h200, 10, 5, 2, 1'b0, 2, 0);
        tick();
        chk("midswap_pix_copy_cycle", ia.pixel_out, 1'b0);
        tick();
        chk("midswap_pix_after", ia.pixel_out, 1'b1);
        for (int r = 0; r < 32; r++) m_front[r] = m_back[r];
        scan_a("midswap");
        clear_a();
        scan_a("front_intact");
        swap_a();
        scan_a("cleared_swap");

        // Wide instance: wrap at the far corner
        ib.sprite_addr_in = 12'h300;
        ib.sprite_x_in    = 7'd124;
        ib.sprite_y_in    = 6'd63;
        ib.sprite_n_in    = 4'd2;
        ib.clip_in        = 1'b0;
        ib.draw_in        = 1'b1;
        tick();
        ib.draw_in = 1'b0;
        dcyc = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) tick();
            if (ib.done_out && dcyc < 0) dcyc = c;
        end
        chk("b_done_cycle", dcyc, 6);
        chk("b_collision", ib.collision_out, 1'b0);
        ib.swap_in = 1'b1;
        tick();
        ib.swap_in = 1'b0;
        tick(); tick();
        pix_b("b_pix_0_0", 0, 0, 1'b1);
        pix_b("b_pix_127_63", 127, 63, 1'b1);
        pix_b("b_pix_123_63", 123, 63, 1'b0);
        pix_b("b_pix_4_0", 4, 0, 1'b0);

        // Reset in the middle of a second draw
        ib.draw_in = 1'b1;
        tick();
        ib.draw_in = 1'b0;
        tick();
        tick();
        rst_b_n = 1'b0;
        tick();
        outs_zero_b("b_midrst");
        rst_b_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("b_no_done_after_rst", ib.done_out, 1'b0);
        end
        scan_b_zero("b_front_after_rst");
        ib.swap_in = 1'b1;
        tick();
        ib.swap_in = 1'b0;
        tick(); tick();
        scan_b_zero("b_back_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
